// File: rtl/jt49_eg_ctrl.sv
// ---------------------------------------------------------------------------
// jt49_eg_ctrl -- envelope sequencer for the PSG envelope generator.
//
// Holds the envelope period (R11 fine / R12 coarse) and shape (R13)
// registers. It produces the registered `step` and `restart` strobes that
// drive the envelope generator datapath. All envelope timing advances only
// on cycles where cen=1. Register writes take effect on any clk edge.
//
// Ports:
//   clk     in   core clock
//   rst     in   synchronous reset, active-high
//   cen     in   clock enable for all envelope timing
//   wr      in   register write strobe (one clk, not gated by cen)
//   addr    in   [3:0] register address (0xB, 0xC, 0xD are decoded)
//   din     in   [7:0] write data
//   step    out  envelope step request, high for one cen interval
//   restart out  envelope restart request, high for one cen interval
//   ctrl    out  [3:0] envelope shape {CONT, ATT, ALT, HOLD}
//   period  out  [15:0] current envelope period {R12, R11}
// ---------------------------------------------------------------------------
module jt49_eg_ctrl #(
  parameter int DIV = 8,   // cen pulses per period unit, 2..256
  parameter int CW  = 16   // period counter width, >= 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [7:0]  din,
  output logic        step,
  output logic        restart,
  output logic [3:0]  ctrl,
  output logic [15:0] period
);

  localparam int            PW         = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [15:0]   period_q, period_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          pend_q, pend_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          restart_q, restart_d;

  logic [15:0]   eff_period_s;
  logic [CW-1:0] cnt_inc_s;
  logic          shape_wr_s;

  // Period 0 behaves like period 1; incremented count used for the compare.
  always_comb begin
    if (period_q == 16'd0) begin
      eff_period_s = 16'd1;
    end else begin
      eff_period_s = period_q;
    end
    cnt_inc_s  = cnt_q + CW'(1);
    shape_wr_s = wr && (addr == 4'hD);
  end

  // Next-state logic: register writes, restart delivery and stepping.
  always_comb begin
    period_d  = period_q;
    ctrl_d    = ctrl_q;
    pend_d    = pend_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    restart_d = restart_q;

    if (cen) begin
      if (pend_q) begin
        // Restart wins; any step that would have fired here is dropped.
        restart_d = 1'b1;
        step_d    = 1'b0;
        pend_d    = 1'b0;
        presc_d   = '0;
        cnt_d     = '0;
      end else begin
        restart_d = 1'b0;
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          // >= (not ==) so a period lowered below the current count
          // still fires at the next wrap instead of running away.
          if (cnt_inc_s >= CW'(eff_period_s)) begin
            cnt_d  = '0;
            step_d = 1'b1;
          end else begin
            cnt_d  = cnt_inc_s;
            step_d = 1'b0;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          step_d  = 1'b0;
        end
      end
    end else begin
      step_d    = step_q;
      restart_d = restart_q;
    end

    // A shape write on a delivery edge re-arms pend for the next cen.
    if (wr) begin
      case (addr)
        4'hB: period_d[7:0]  = din;
        4'hC: period_d[15:8] = din;
        4'hD: ctrl_d         = din[3:0];
        default: period_d    = period_d;
      endcase
    end else begin
      period_d = period_d;
    end

    if (shape_wr_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q  <= 16'd0;
      ctrl_q    <= 4'd0;
      pend_q    <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      restart_q <= restart_d;
    end
  end

  assign step    = step_q;
  assign restart = restart_q;
  assign ctrl    = ctrl_q;
  assign period  = period_q;

endmodule

// File: tb/tb_jt49_eg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jt49_eg_ctrl -- self-checking bench for jt49_eg_ctrl.
// Directed scenarios check fixed expectations. A randomized run checks
// against a reference model that tracks the cen pulses elapsed since the
// last step/restart. A step is due when that count is a whole number of
// prescaler periods reaching eff_period.
// ---------------------------------------------------------------------------
module tb_jt49_eg_ctrl;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst, cen, wr;
  logic [3:0]  addr;
  logic [7:0]  din;
  logic        step, restart;
  logic [3:0]  ctrl;
  logic [15:0] period;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_period = 16'd0;
  logic [3:0]  m_ctrl   = 4'd0;
  bit          m_pend   = 1'b0;
  int          m_elapsed = 0;
  bit          m_step    = 1'b0;
  bit          m_restart = 1'b0;

  always #5 clk = ~clk;

  jt49_eg_ctrl #(.DIV(DIV), .CW(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .wr     (wr),
    .addr   (addr),
    .din    (din),
    .step   (step),
    .restart(restart),
    .ctrl   (ctrl),
    .period (period)
  );

  task automatic model_edge(input logic r, input logic c, input logic w,
                            input logic [3:0] a, input logic [7:0] d);
    int eff;
    if (r) begin
      m_period = 16'd0; m_ctrl = 4'd0; m_pend = 1'b0;
      m_elapsed = 0; m_step = 1'b0; m_restart = 1'b0;
    end else begin
      eff = (m_period == 16'd0) ? 1 : int'(m_period);
      if (c) begin
        if (m_pend) begin
          m_restart = 1'b1; m_step = 1'b0; m_elapsed = 0; m_pend = 1'b0;
        end else begin
          m_restart = 1'b0;
          m_elapsed++;
          if ((m_elapsed % DIV == 0) && (m_elapsed / DIV >= eff)) begin
            m_step = 1'b1;
            m_elapsed = 0;
          end else begin
            m_step = 1'b0;
          end
        end
      end
      if (w) begin
        case (a)
          4'hB: m_period[7:0]  = d;
          4'hC: m_period[15:8] = d;
          4'hD: begin m_ctrl = d[3:0]; m_pend = 1'b1; end
          default: ;
        endcase
      end
    end
  endtask

  // Drive inputs on the falling edge, update the model at the rising edge,
  // and return 1 time unit later so outputs can be sampled.
  task automatic tick(input logic r, input logic c, input logic w,
                      input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = r; cen = c; wr = w; addr = a; din = d;
    @(posedge clk);
    model_edge(r, c, w, a, d);
    #1;
  endtask

  task automatic do_reset();                       tick(1'b1, 1'b0, 1'b0, 4'h0, 8'h00); endtask
  task automatic idle();                           tick(1'b0, 1'b0, 1'b0, 4'h0, 8'h00); endtask
  task automatic cen_tick();                       tick(1'b0, 1'b1, 1'b0, 4'h0, 8'h00); endtask
  task automatic wrreg(input logic [3:0] a, input logic [7:0] d); tick(1'b0, 1'b0, 1'b1, a, d); endtask

  task automatic test_reset();
    int n_step = 0, first = 0, n_rst = 0;
    do_reset();
    total++; if (step !== 1'b0)     begin bad++; $display("FAIL reset_step: got %0d expected 0", step); end
    total++; if (restart !== 1'b0)  begin bad++; $display("FAIL reset_restart: got %0d expected 0", restart); end
    total++; if (ctrl !== 4'h0)     begin bad++; $display("FAIL reset_ctrl: got %0d expected 0", ctrl); end
    total++; if (period !== 16'h0)  begin bad++; $display("FAIL reset_period: got %0d expected 0", period); end
    wrreg(4'hB, 8'd3);
    total++; if (period !== 16'd3)  begin bad++; $display("FAIL period_wr: got %0d expected 3", period); end
    for (int i = 1; i <= 48; i++) begin
      idle();
      cen_tick();
      if (step === 1'b1) begin n_step++; if (first == 0) first = i; end
      if (restart === 1'b1) n_rst++;
    end
    total++; if (n_step != 2)  begin bad++; $display("FAIL p3_step_count: got %0d expected 2", n_step); end
    total++; if (first != 24)  begin bad++; $display("FAIL p3_first_step: got %0d expected 24", first); end
    total++; if (n_rst != 0)   begin bad++; $display("FAIL p3_restart_count: got %0d expected 0", n_rst); end
  endtask

  task automatic test_period_small();
    for (int p = 0; p <= 1; p++) begin
      int n_step = 0, first = 0;
      do_reset();
      wrreg(4'hB, 8'(p));
      for (int i = 1; i <= 32; i++) begin
        cen_tick();
        if (step === 1'b1) begin n_step++; if (first == 0) first = i; end
      end
      total++; if (n_step != 4) begin bad++; $display("FAIL small_p%0d_count: got %0d expected 4", p, n_step); end
      total++; if (first != 8)  begin bad++; $display("FAIL small_p%0d_first: got %0d expected 8", p, first); end
    end
  endtask

  task automatic test_shape_write();
    int n_rst = 0, first = 0;
    do_reset();
    wrreg(4'hB, 8'd2);
    for (int i = 0; i < 5; i++) cen_tick();
    tick(1'b0, 1'b1, 1'b1, 4'hD, 8'h0E);
    total++; if (ctrl !== 4'hE)    begin bad++; $display("FAIL shape_ctrl: got %0d expected 14", ctrl); end
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL shape_restart_early: got %0d expected 0", restart); end
    cen_tick();
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL shape_restart: got %0d expected 1", restart); end
    total++; if (step !== 1'b0)    begin bad++; $display("FAIL shape_step_with_restart: got %0d expected 0", step); end
    for (int i = 1; i <= 40; i++) begin
      cen_tick();
      if (restart === 1'b1) n_rst++;
      if (step === 1'b1 && first == 0) first = i;
    end
    total++; if (n_rst != 0)  begin bad++; $display("FAIL shape_restart_extra: got %0d expected 0", n_rst); end
    total++; if (first != 16) begin bad++; $display("FAIL shape_next_step: got %0d expected 16", first); end
  endtask

  task automatic test_double_write();
    int n_rst = 0;
    do_reset();
    wrreg(4'hD, 8'h09);
    wrreg(4'hD, 8'h04);
    idle();
    cen_tick();
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL dbl_restart: got %0d expected 1", restart); end
    total++; if (ctrl !== 4'h4)    begin bad++; $display("FAIL dbl_ctrl: got %0d expected 4", ctrl); end
    for (int i = 0; i < 20; i++) begin
      cen_tick();
      if (restart === 1'b1) n_rst++;
    end
    total++; if (n_rst != 0) begin bad++; $display("FAIL dbl_extra_restart: got %0d expected 0", n_rst); end
  endtask

  task automatic test_midcount();
    int n_step = 0, first = 0, second = 0;
    do_reset();
    wrreg(4'hB, 8'd100);
    for (int i = 0; i < 403; i++) begin
      cen_tick();
      if (step === 1'b1) n_step++;
    end
    total++; if (n_step != 0) begin bad++; $display("FAIL mid_early_step: got %0d expected 0", n_step); end
    wrreg(4'hB, 8'd10);
    for (int i = 1; i <= 100; i++) begin
      cen_tick();
      if (step === 1'b1) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    total++; if (first != 5)   begin bad++; $display("FAIL mid_first: got %0d expected 5", first); end
    total++; if (second != 85) begin bad++; $display("FAIL mid_second: got %0d expected 85", second); end
  endtask

  task automatic test_reset_pending();
    int n_rst = 0, first = 0;
    do_reset();
    wrreg(4'hB, 8'd5);
    for (int i = 0; i < 40; i++) cen_tick();
    total++; if (step !== 1'b1) begin bad++; $display("FAIL rp_step_before: got %0d expected 1", step); end
    wrreg(4'hD, 8'h03);
    do_reset();
    total++; if (step !== 1'b0)    begin bad++; $display("FAIL rp_step: got %0d expected 0", step); end
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL rp_restart: got %0d expected 0", restart); end
    total++; if (ctrl !== 4'h0)    begin bad++; $display("FAIL rp_ctrl: got %0d expected 0", ctrl); end
    total++; if (period !== 16'h0) begin bad++; $display("FAIL rp_period: got %0d expected 0", period); end
    for (int i = 1; i <= 40; i++) begin
      cen_tick();
      if (restart === 1'b1) n_rst++;
      if (step === 1'b1 && first == 0) first = i;
    end
    total++; if (n_rst != 0) begin bad++; $display("FAIL rp_restart_after: got %0d expected 0", n_rst); end
    total++; if (first != 8) begin bad++; $display("FAIL rp_first_step: got %0d expected 8", first); end
  endtask

  task automatic test_random();
    logic       r, c, w;
    logic [3:0] a;
    logic [7:0] d;
    int         sel;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      c   = 1'($urandom_range(0, 1));
      w   = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin a = 4'hB; d = 8'($urandom_range(0, 15)); end
        1: begin a = 4'hC; d = 8'($urandom_range(0, 1) == 0 ? 0 : 1); end
        2: begin a = 4'hD; d = 8'($urandom_range(0, 255)); end
        default: begin a = 4'($urandom_range(0, 10)); d = 8'($urandom_range(0, 255)); end
      endcase
      tick(r, c, w, a, d);
      total++; if (step !== m_step)       begin bad++; $display("FAIL rnd_step cyc %0d: got %0d expected %0d", i, step, m_step); end
      total++; if (restart !== m_restart) begin bad++; $display("FAIL rnd_restart cyc %0d: got %0d expected %0d", i, restart, m_restart); end
      total++; if (ctrl !== m_ctrl)       begin bad++; $display("FAIL rnd_ctrl cyc %0d: got %0d expected %0d", i, ctrl, m_ctrl); end
      total++; if (period !== m_period)   begin bad++; $display("FAIL rnd_period cyc %0d: got %0d expected %0d", i, period, m_period); end
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; wr = 1'b0; addr = 4'h0; din = 8'h00;
    test_reset();
    test_period_small();
    test_shape_write();
    test_double_write();
    test_midcount();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt49_eg_ctrl.md
Name: jt49_eg_ctrl

Overview:
- Envelope sequencer for the PSG envelope generator.
- Owns the envelope period registers (R11 fine, R12 coarse) and the shape register (R13), all written from the CPU register bus.
- Produces the `step` and `restart` strobes and the 4-bit shape `ctrl` that drive the envelope generator datapath, all qualified by the core clock enable.
- Sits between the register file decoder and the envelope generator in the PSG top level.

Parameters:
- DIV, 8: number of cen pulses per envelope period unit (prescaler modulus). Legal range 2..256.
- CW, 16: width of the period counter. Must be ≥16.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- cen  input  1  clock enable; all envelope timing advances only on cycles with cen=1
- wr  input  1  register write strobe, one clk cycle, not gated by cen
- addr  input  4  register address
- din  input  8  write data
- step  output  1  envelope step request to the generator
- restart  output  1  envelope restart request to the generator
- ctrl  output  4  envelope shape {CONT, ATT, ALT, HOLD}
- period  output  16  current envelope period {R12, R11}, for readback

Behaviour:
- Reset (rst=1 at a clk edge, takes priority over everything):
  - period=0, ctrl=0, step=0, restart=0.
  - Prescaler, period counter and restart-pending flag all cleared.
  - Reset mid-count or with a restart pending discards that state entirely.
- Register writes (any clk cycle with wr=1, independent of cen):
  - addr=0xB: period[7:0]←din.
  - addr=0xC: period[15:8]←din.
  - addr=0xD: ctrl←din[3:0], pend←1. Rewriting an identical value still sets pend.
  - Other addresses are ignored.
  - period and ctrl update on the clk edge after the write.
- Strobe timing:
  - step and restart are registered and update only on cen cycles.
  - Each is high for exactly one cen interval, i.e. sampled high by exactly one downstream cen.
- Restart delivery:
  - On the first cen cycle strictly after the R13 write edge: restart←1, step←0, pend←0, prescaler←0, counter←0.
  - A shape write on the same clk edge as a cen is captured, but its restart is issued on the following cen.
  - A second R13 write before delivery yields a single restart; ctrl holds the last written value.
- Stepping, on each cen cycle with no restart being delivered:
  - Prescaler counts 0..DIV-1, then wraps.
  - On wrap, the counter increments.
  - When the incremented value ≥ eff_period (eff_period = period, or 1 when period=0): counter←0 and step←1 for that cen interval. Otherwise step←0.
  - step frequency = f_cen / (DIV × eff_period).
- Mid-count period write:
  - The counter is not reset.
  - If the new eff_period ≤ the current count, step fires at the next prescaler wrap, then normal cadence resumes.
  - Comparison is CW-bit unsigned; no wrap-around of the counter is possible.
- restart has priority over step on the same cen; that step is lost, not deferred.
- The block never issues restart and step in the same interval.
- With cen held low, no outputs change except period and ctrl on writes.

Test Plan:
- Reset with DIV=8, cen every 2 clk, period=3 → after 48 cen pulses exactly 2 step pulses, the first at cen #24; restart stays 0.
- period=0 and period=1 → step every 8 cen pulses in both cases.
- Write R13=0xE on a cycle with cen=1 → ctrl=0xE on the next edge; restart high on the next cen interval only; the next step occurs 8×eff_period cen pulses later.
- Write R13=0x9 then R13=0x4 before any cen → one restart pulse; ctrl=0x4.
- period=100, count reaches 50, then write R11=10 with R12=0 → step at the next prescaler wrap, then every 80 cen pulses.
- Assert rst for one cycle while restart is pending and the count is mid-period → all outputs 0; no restart follows; the first step comes 8 cen pulses after release (period=0 → eff 1).
